// File: rtl/ise_result_collector.sv
// ise_result_collector
// Downstream stage of the image sorting engine. Captures the sorted result
// burst into a first-word-fall-through FIFO served to a host over valid/ready,
// and publishes per-frame dominant-colour statistics (R/G/B counts, length).

module ise_result_collector #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          out_valid_in,
  input  logic [1:0]    color_index_in,
  input  logic [4:0]    image_out_index_in,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [1:0]    rd_color,
  output logic [4:0]    rd_image,
  output logic [AW:0]   level,
  output logic          full,
  output logic          overflow,
  output logic          frame_done,
  output logic [5:0]    frame_len,
  output logic [5:0]    r_cnt,
  output logic [5:0]    g_cnt,
  output logic [5:0]    b_cnt
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  // Each entry packs {colour, image index}.
  logic [6:0]  r_mem [DEPTH];
  logic [AW:0] r_wrPtr;
  logic [AW:0] r_rdPtr;
  logic        r_overflow;

  logic [0:0]  r_state;
  logic [5:0]  r_liveLen;
  logic [5:0]  r_liveR;
  logic [5:0]  r_liveG;
  logic [5:0]  r_liveB;
  logic        r_frameDone;
  logic [5:0]  r_frameLen;
  logic [5:0]  r_rCnt;
  logic [5:0]  r_gCnt;
  logic [5:0]  r_bCnt;

  logic [AW:0] w_level;
  logic        w_full;
  logic        w_rdValid;
  logic        w_push;
  logic        w_pop;
  logic [6:0]  w_head;

  // Frame counters stick at 63 rather than wrapping on very long bursts.
  function automatic logic [5:0] satInc(input logic [5:0] value);
    return (value == 6'd63) ? value : value + 6'd1;
  endfunction

  // Extra pointer MSB tells full (MSBs differ) from empty (MSBs match), so the
  // difference of the two pointers is the occupancy directly.
  assign w_level   = r_wrPtr - r_rdPtr;
  assign w_full    = (w_level == FULL_LEVEL);
  assign w_rdValid = (w_level != '0);
  assign w_pop     = w_rdValid && rd_ready;
  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign w_push    = out_valid_in && (!w_full || w_pop);
  assign w_head    = r_mem[r_rdPtr[AW-1:0]];

  assign rd_valid   = w_rdValid;
  // Head data is masked while empty so stale memory never reaches the host.
  assign rd_color   = w_rdValid ? w_head[6:5] : 2'd0;
  assign rd_image   = w_rdValid ? w_head[4:0] : 5'd0;
  assign level      = w_level;
  assign full       = w_full;
  assign overflow   = r_overflow;
  assign frame_done = r_frameDone;
  assign frame_len  = r_frameLen;
  assign r_cnt      = r_rCnt;
  assign g_cnt      = r_gCnt;
  assign b_cnt      = r_bCnt;

  // Storage array; contents after reset are don't-care, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr[AW-1:0]] <= {color_index_in, image_out_index_in};
    end
  end

  // Pointer advance and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (out_valid_in && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Frame tracking: a burst of consecutive beats is one frame; the first idle
  // cycle closes it, publishes the live counts and pulses frame_done once.
  // Dropped beats still count, since statistics follow the sorter, not the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_liveLen   <= '0;
      r_liveR     <= '0;
      r_liveG     <= '0;
      r_liveB     <= '0;
      r_frameDone <= 1'b0;
      r_frameLen  <= '0;
      r_rCnt      <= '0;
      r_gCnt      <= '0;
      r_bCnt      <= '0;
    end else begin
      r_frameDone <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (out_valid_in) begin
            r_state   <= ST_COLLECT;
            r_liveLen <= 6'd1;
            r_liveR   <= (color_index_in == 2'd0) ? 6'd1 : 6'd0;
            r_liveG   <= (color_index_in == 2'd1) ? 6'd1 : 6'd0;
            r_liveB   <= (color_index_in == 2'd2) ? 6'd1 : 6'd0;
          end
        end
        ST_COLLECT: begin
          if (out_valid_in) begin
            r_liveLen <= satInc(r_liveLen);
            if (color_index_in == 2'd0) begin
              r_liveR <= satInc(r_liveR);
            end
            if (color_index_in == 2'd1) begin
              r_liveG <= satInc(r_liveG);
            end
            if (color_index_in == 2'd2) begin
              r_liveB <= satInc(r_liveB);
            end
          end else begin
            r_state     <= ST_IDLE;
            r_frameDone <= 1'b1;
            r_frameLen  <= r_liveLen;
            r_rCnt      <= r_liveR;
            r_gCnt      <= r_liveG;
            r_bCnt      <= r_liveB;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ise_result_collector.sv
// tb_ise_result_collector
// Self-checking bench: directed bursts plus a randomized phase, all compared
// against a queue-based reference model of the FIFO and frame statistics.

module tb_ise_result_collector;

   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic          clk;
   logic          reset;
   logic          outValid;
   logic [1:0]    colorIn;
   logic [4:0]    imageIn;
   logic          rdReady;
   logic          rdValid;
   logic [1:0]    rdColor;
   logic [4:0]    rdImage;
   logic [AW:0]   level;
   logic          full;
   logic          overflow;
   logic          frameDone;
   logic [5:0]    frameLen;
   logic [5:0]    rCnt;
   logic [5:0]    gCnt;
   logic [5:0]    bCnt;

   int testsRun;
   int testsFailed;
   int donePulses;

   // Reference model state
   logic [6:0] modelQ [$];
   bit         modelOvf;
   bit         modelInFrame;
   bit         modelDone;
   int         liveLen, liveR, liveG, liveB;
   int         statLen, statR, statG, statB;

   ise_result_collector #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk                (clk),
      .reset              (reset),
      .out_valid_in       (outValid),
      .color_index_in     (colorIn),
      .image_out_index_in (imageIn),
      .rd_ready           (rdReady),
      .rd_valid           (rdValid),
      .rd_color           (rdColor),
      .rd_image           (rdImage),
      .level              (level),
      .full               (full),
      .overflow           (overflow),
      .frame_done         (frameDone),
      .frame_len          (frameLen),
      .r_cnt              (rCnt),
      .g_cnt              (gCnt),
      .b_cnt              (bCnt)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   function automatic int sat63(input int v);
      return (v > 63) ? 63 : v;
   endfunction

   task automatic clearModel();
      modelQ.delete();
      modelOvf     = 1'b0;
      modelInFrame = 1'b0;
      modelDone    = 1'b0;
      liveLen = 0; liveR = 0; liveG = 0; liveB = 0;
      statLen = 0; statR = 0; statG = 0; statB = 0;
   endtask

   // Holds reset for n cycles while optionally presenting a beat, then clears the model.
   task automatic resetDut(input int n, input bit v);
      reset    = 1'b1;
      outValid = v;
      colorIn  = 2'd1;
      imageIn  = 5'd2;
      rdReady  = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      reset    = 1'b0;
      outValid = 1'b0;
      clearModel();
      #1;
      checkOutput("rst_rd_valid", rdValid, 0);
      checkOutput("rst_level", level, 0);
      checkOutput("rst_overflow", overflow, 0);
      checkOutput("rst_frame_done", frameDone, 0);
      checkOutput("rst_frame_len", frameLen, 0);
   endtask

   // One clock cycle: drive inputs, check pre-edge outputs, advance the model.
   task automatic applyStimulus(input bit v, input int c, input int img, input bit rdy);
      bit doPop, doPush;
      logic [1:0] c2;
      logic [4:0] i5;
      c2 = c[1:0];
      i5 = img[4:0];
      outValid = v;
      colorIn  = c2;
      imageIn  = i5;
      rdReady  = rdy;
      #1;
      checkOutput("rd_valid", rdValid, (modelQ.size() != 0) ? 1 : 0);
      if (modelQ.size() != 0) begin
         checkOutput("rd_color", rdColor, modelQ[0][6:5]);
         checkOutput("rd_image", rdImage, modelQ[0][4:0]);
      end
      checkOutput("level", level, modelQ.size());
      checkOutput("full", full, (modelQ.size() == DEPTH) ? 1 : 0);
      checkOutput("overflow", overflow, modelOvf);
      checkOutput("frame_done", frameDone, modelDone);
      checkOutput("frame_len", frameLen, statLen);
      checkOutput("r_cnt", rCnt, statR);
      checkOutput("g_cnt", gCnt, statG);
      checkOutput("b_cnt", bCnt, statB);
      if (frameDone === 1'b1) donePulses++;

      // FIFO: host takes the head if any; a beat enters if there is room after that.
      doPop  = (modelQ.size() != 0) && rdy;
      doPush = v && ((modelQ.size() < DEPTH) || doPop);
      if (doPop) void'(modelQ.pop_front());
      if (doPush) modelQ.push_back({c2, i5});
      if (v && !doPush) modelOvf = 1'b1;

      // Frames: consecutive beats form one frame; an idle cycle publishes it.
      modelDone = 1'b0;
      if (v) begin
         if (!modelInFrame) begin
            modelInFrame = 1'b1;
            liveLen = 0; liveR = 0; liveG = 0; liveB = 0;
         end
         liveLen = sat63(liveLen + 1);
         if (c2 == 2'd0) liveR = sat63(liveR + 1);
         if (c2 == 2'd1) liveG = sat63(liveG + 1);
         if (c2 == 2'd2) liveB = sat63(liveB + 1);
      end else if (modelInFrame) begin
         modelInFrame = 1'b0;
         modelDone = 1'b1;
         statLen = liveLen; statR = liveR; statG = liveG; statB = liveB;
      end

      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n, input bit rdy);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 0, 0, rdy);
   endtask

   initial begin
      int colors[7];
      int cyc;
      testsRun    = 0;
      testsFailed = 0;
      donePulses  = 0;
      reset    = 1'b1;
      outValid = 1'b0;
      colorIn  = '0;
      imageIn  = '0;
      rdReady  = 1'b0;
      clearModel();

      // Reset state
      resetDut(3, 1'b0);

      // 7-beat burst R,G,B,R,R,G,none read back in order
      colors = '{0, 1, 2, 0, 0, 1, 3};
      donePulses = 0;
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, colors[i], i, 1'b1);
      idleCycles(4, 1'b1);
      checkOutput("b7_frame_len", frameLen, 7);
      checkOutput("b7_r_cnt", rCnt, 3);
      checkOutput("b7_g_cnt", gCnt, 2);
      checkOutput("b7_b_cnt", bCnt, 1);
      checkOutput("b7_done_pulses", donePulses, 1);

      // Fill to full with no reads, then one extra beat is dropped
      for (int i = 0; i < 33; i++) applyStimulus(1'b1, $urandom_range(3), i, 1'b0);
      checkOutput("ovf_level", level, 32);
      checkOutput("ovf_full", full, 1);
      checkOutput("ovf_set", overflow, 1);
      idleCycles(34, 1'b1);
      checkOutput("ovf_drained", level, 0);
      checkOutput("ovf_sticky", overflow, 1);
      checkOutput("ovf_frame_len", frameLen, 33);

      // Full FIFO with simultaneous push and pop: nothing lost
      resetDut(1, 1'b0);
      for (int i = 0; i < 32; i++) applyStimulus(1'b1, $urandom_range(3), i, 1'b0);
      applyStimulus(1'b1, 2, 31, 1'b1);
      checkOutput("pp_level", level, 32);
      checkOutput("pp_no_ovf", overflow, 0);
      idleCycles(34, 1'b1);
      checkOutput("pp_drained", level, 0);

      // Three 20-beat bursts with toggling ready to wrap the pointers
      cyc = 0;
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, $urandom_range(3), $urandom_range(31), cyc[0]);
            cyc++;
         end
         idleCycles(2, 1'b1);
      end
      idleCycles(40, 1'b1);
      checkOutput("wrap_level", level, 0);

      // Two bursts of 4 and 5 separated by a single idle cycle
      donePulses = 0;
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, i % 4, i, 1'b1);
      applyStimulus(1'b0, 0, 0, 1'b1);
      checkOutput("two_frame1_len", frameLen, 4);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 0, i, 1'b1);
      idleCycles(3, 1'b1);
      checkOutput("two_frame2_len", frameLen, 5);
      checkOutput("two_frame2_r", rCnt, 5);
      checkOutput("two_done_pulses", donePulses, 2);

      // Reset landing on beat 3 of a burst discards the partial frame
      applyStimulus(1'b1, 0, 1, 1'b0);
      applyStimulus(1'b1, 1, 2, 1'b0);
      donePulses = 0;
      resetDut(1, 1'b1);
      idleCycles(2, 1'b0);
      checkOutput("mid_no_done", donePulses, 0);
      applyStimulus(1'b1, 2, 7, 1'b1);
      applyStimulus(1'b1, 2, 8, 1'b1);
      idleCycles(3, 1'b1);
      checkOutput("mid_frame_len", frameLen, 2);
      checkOutput("mid_b_cnt", bCnt, 2);
      checkOutput("mid_done_pulses", donePulses, 1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(3) != 0), $urandom_range(3), $urandom_range(31), $urandom_range(1));
      end
      idleCycles(40, 1'b1);
      checkOutput("rand_drained", level, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
